// File: rtl/skid_reg_pkg.sv
// Shared types and constants for the skid_reg two-entry elastic pipeline register.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_reg_sreg.sv
// Plain W-bit holding register with load enable and synchronous active-high clear.
module skid_reg_sreg
  import skid_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)      q <= '0;
    else if (ena) q <= d;
  end

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid buffer: registered out_data/out_valid and a state-only in_ready.
// Optional saturating stall counter enabled by defining SKID_REG_STALL_CNT_EN.
module skid_reg
  import skid_reg_pkg::*;
#(
  parameter int W  = 8
`ifdef SKID_REG_STALL_CNT_EN
  ,
  parameter int CW = 16
`endif
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
`ifdef SKID_REG_STALL_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt
`endif
);

  skid_state_t  state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer;
  logic         main_ena, skid_ena;
  logic [W-1:0] main_d, main_q, skid_q;

  assign in_xfer = in_valid & in_ready;

  // The skid entry only ever fills from ONE under back-pressure and only ever drains into main.
  always_comb begin
    state_d  = state_q;
    main_ena = 1'b0;
    skid_ena = 1'b0;
    main_d   = in_data;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_ena = 1'b1;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_ready) begin
          main_ena = 1'b1;
        end else if (in_xfer) begin
          skid_ena = 1'b1;
          state_d  = TWO;
        end else if (out_ready) begin
          state_d  = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          main_d   = skid_q;
          main_ena = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != skid_state_t'(SKID_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  skid_reg_sreg #(.W(W)) u_main (
    .clk (clk),
    .clr (clr),
    .ena (main_ena),
    .d   (main_d),
    .q   (main_q)
  );

  skid_reg_sreg #(.W(W)) u_skid (
    .clk (clk),
    .clr (clr),
    .ena (skid_ena),
    .d   (in_data),
    .q   (skid_q)
  );

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign in_ready  = in_ready_q & ~clr;

`ifdef SKID_REG_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Directed self-checking bench for skid_reg; covers stall counter when SKID_REG_STALL_CNT_EN is defined.
module tb_skid_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef SKID_REG_STALL_CNT_EN
  logic [3:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef SKID_REG_STALL_CNT_EN
  skid_reg #(.W(W), .CW(4)) dut (
`else
  skid_reg #(.W(W)) dut (
`endif
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, let combinational in_ready settle before the next edge.
  task automatic applyStimulus(input logic c, input logic v, input logic [W-1:0] d, input logic r);
    clr       = c;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Test 1: reset held for three cycles with a valid word offered
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    checkOutput("rst_in_ready_pre", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'h00);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_first_ready", 32'(in_ready), 32'd1);

    // Test 2: full-throughput streaming of 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_data", 32'(out_data), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("stream_drain_valid", 32'(out_valid), 32'd0);

    // Test 3: back-pressure fills both entries, then drains in order
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    tick();
    checkOutput("bp_data_11", 32'(out_data), 32'h11);
    checkOutput("bp_ready_one", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
    tick();
    checkOutput("bp_ready_two", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_data", 32'(out_data), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    tick();
    checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_data2", 32'(out_data), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b1);
    checkOutput("bp_drain_0", 32'(out_data), 32'h11);
    tick();
    checkOutput("bp_drain_1", 32'(out_data), 32'h22);
    checkOutput("bp_drain_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("bp_drain_2", 32'(out_data), 32'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Test 4: simultaneous in/out transfer while holding one word
    applyStimulus(1'b0, 1'b1, 8'hA0, 1'b1);
    tick();
    checkOutput("sim_first", 32'(out_data), 32'hA0);
    applyStimulus(1'b0, 1'b1, 8'h5C, 1'b1);
    tick();
    checkOutput("sim_replace", 32'(out_data), 32'h5C);
    checkOutput("sim_ready_one", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("sim_to_empty", 32'(out_valid), 32'd0);

    // Test 5: reset while both entries are occupied
    applyStimulus(1'b0, 1'b1, 8'h44, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    tick();
    checkOutput("mid_two", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_data", 32'(out_data), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mid_no_replay", 32'(out_valid), 32'd0);
    end

`ifdef SKID_REG_STALL_CNT_EN
    // Test 6: stall counter saturates at 15 with CW = 4
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("cnt_reset", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b0);
    tick();
    checkOutput("cnt_start", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) checkOutput("cnt_14", 32'(stall_cnt), 32'd14);
      if (i == 15) checkOutput("cnt_15", 32'(stall_cnt), 32'd15);
    end
    checkOutput("cnt_sat", 32'(stall_cnt), 32'd15);
    checkOutput("cnt_stable_data", 32'(out_data), 32'h66);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("cnt_clr", 32'(stall_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
